// File: rtl/tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the FSM encoding, the default word width and the counter sizing helper.
package tx_pkg;

  typedef enum logic {
    StIdle,
    StShift
  } tx_state_e;

  localparam int unsigned WIDTH_DEFAULT = 4;

  // Bits needed to hold WIDTH-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_cnt.sv
// Loadable down-counter with a zero flag.
// Tracks the bits remaining in the frame currently on the line.
module bit_cnt #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [Width-1:0] i_load_val,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with selectable bit order.
// Accepts a new word on the last bit of a frame so frames can run back to back.
module piso_tx
  import tx_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic             direc,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  tx_state_e        r_state, w_state_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic             r_msb_first, w_msb_first_d;
  logic             r_first, w_first_d;
  logic             r_armed;
  logic             w_accept;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  // r_armed keeps load_ready low until the first edge after reset release.
  assign load_ready = r_armed && ((r_state == StIdle) || w_cnt_zero);
  assign w_accept   = load_valid && load_ready;

  always_comb begin
    w_state_d     = r_state;
    w_shift_d     = r_shift;
    w_msb_first_d = r_msb_first;
    w_first_d     = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_dec     = 1'b0;
    if (w_accept) begin
      w_state_d     = StShift;
      w_shift_d     = d_in;
      w_msb_first_d = direc;
      w_first_d     = 1'b1;
      w_cnt_load    = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: ;
        StShift: begin
          if (w_cnt_zero) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_dec = 1'b1;
            w_shift_d = r_msb_first ? (r_shift << 1) : (r_shift >> 1);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_msb_first <= 1'b1;
      r_first     <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_shift     <= w_shift_d;
      r_msb_first <= w_msb_first_d;
      r_first     <= w_first_d;
      r_armed     <= 1'b1;
    end
  end

  bit_cnt #(
    .Width (CntW)
  ) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (CntW'(WIDTH - 1)),
    .o_zero     (w_cnt_zero)
  );

  // All outputs are selected purely from registered state.
  assign busy        = (r_state == StShift);
  assign sout_valid  = busy;
  assign frame_start = r_first;
  assign sout        = busy ? (r_msb_first ? r_shift[WIDTH-1] : r_shift[0]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed vector table, hand-written corner
// sequences and a randomized run against a bit-queue reference model.
module tb_piso_tx;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lv, dir;
  logic [W-1:0] din;
  logic         ready, sout, svalid, fs, busy;
  logic         lv8, dir8;
  logic [7:0]   din8;
  logic         ready8, sout8, svalid8, fs8, busy8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_tx #(
    .WIDTH      (W),
    .IDLE_LEVEL (1'b0)
  ) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (lv),
    .load_ready  (ready),
    .d_in        (din),
    .direc       (dir),
    .sout        (sout),
    .sout_valid  (svalid),
    .frame_start (fs),
    .busy        (busy)
  );

  piso_tx #(
    .WIDTH      (8),
    .IDLE_LEVEL (1'b1)
  ) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (lv8),
    .load_ready  (ready8),
    .d_in        (din8),
    .direc       (dir8),
    .sout        (sout8),
    .sout_valid  (svalid8),
    .frame_start (fs8),
    .busy        (busy8)
  );

  typedef struct {
    logic         lv;
    logic [W-1:0] d;
    logic         dir;
    logic [3:0]   exp;  // {sout, sout_valid, frame_start, load_ready}
  } vec_t;

  typedef struct {
    logic b;
    logic f;
  } bit_t;

  vec_t tbl[24];
  bit_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp8[8];
    logic       mready, accept;
    logic [4:0] mexp;

    tbl[0]  = '{1'b1, 4'b1001, 1'b1, 4'b1110};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0100};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0100};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b1101};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0001};
    tbl[5]  = '{1'b1, 4'b1011, 1'b0, 4'b1110};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b1100};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0100};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b1101};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0001};
    tbl[10] = '{1'b1, 4'b1100, 1'b1, 4'b1110};
    tbl[11] = '{1'b1, 4'b1100, 1'b1, 4'b1100};
    tbl[12] = '{1'b1, 4'b1100, 1'b1, 4'b0100};
    tbl[13] = '{1'b1, 4'b1100, 1'b1, 4'b0101};
    tbl[14] = '{1'b1, 4'b0011, 1'b0, 4'b1110};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 4'b1100};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 4'b0100};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 4'b0101};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 4'b0001};
    tbl[19] = '{1'b1, 4'b0110, 1'b1, 4'b0110};
    tbl[20] = '{1'b1, 4'b1111, 1'b0, 4'b1100};
    tbl[21] = '{1'b0, 4'b0000, 1'b0, 4'b1100};
    tbl[22] = '{1'b1, 4'b1001, 1'b0, 4'b0101};
    tbl[23] = '{1'b0, 4'b0000, 1'b0, 4'b0001};
    exp8 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    lv = 1'b0; din = '0; dir = 1'b0;
    lv8 = 1'b0; din8 = '0; dir8 = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #10;
    check("reset_dut4", {sout, svalid, fs, ready, busy}, 5'b00000);
    check("reset_dut8", {sout8, svalid8, fs8, ready8, busy8}, 5'b10000);
    #10 rst = 1'b1;
    tick();
    check("ready_after_release", {sout, svalid, fs, ready, busy}, 5'b00010);

    // Directed table: single frames, back-to-back, mid-frame input churn
    for (int i = 0; i < 24; i++) begin
      lv = tbl[i].lv; din = tbl[i].d; dir = tbl[i].dir;
      tick();
      check($sformatf("table_row%0d", i), {sout, svalid, fs, ready, busy},
            {tbl[i].exp, tbl[i].exp[2]});
    end

    // Reset asserted mid-frame aborts at once
    lv = 1'b1; din = 4'b1111; dir = 1'b1;
    tick();
    check("abort_bit1", {sout, svalid, fs}, 3'b111);
    lv = 1'b0;
    tick();
    check("abort_bit2", {sout, svalid, fs}, 3'b110);
    #2 rst = 1'b0;
    #1;
    check("abort_async", {sout, svalid, fs, ready, busy}, 5'b00000);
    tick();
    #2 rst = 1'b1;
    tick();
    check("abort_release", {sout, svalid, fs, ready, busy}, 5'b00010);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_bits", {sout, svalid, busy}, 3'b000);
    end

    // WIDTH=8, LSB first, idle level 1
    lv8 = 1'b1; din8 = 8'hA5; dir8 = 1'b0;
    tick();
    lv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check($sformatf("w8_bit%0d", i), {sout8, svalid8, fs8}, {exp8[i], 1'b1, (i == 0)});
    end
    tick();
    check("w8_idle", {sout8, svalid8, fs8, ready8}, 4'b1001);

    // Randomized run against a queue of pending bits
    q.delete();
    for (int c = 0; c < 400; c++) begin
      mready = (q.size() <= 1);
      lv     = ($urandom_range(0, 3) != 0);
      din    = W'($urandom);
      dir    = 1'($urandom);
      accept = lv && mready;
      tick();
      if (q.size() > 0) void'(q.pop_front());
      if (accept) begin
        for (int k = 0; k < int'(W); k++) begin
          q.push_back('{din[dir ? (int'(W) - 1 - k) : k], (k == 0)});
        end
      end
      if (q.size() > 0) mexp = {q[0].b, 1'b1, q[0].f, (q.size() <= 1), 1'b1};
      else              mexp = 5'b00010;
      check($sformatf("random_cycle%0d", c), {sout, svalid, fs, ready, busy}, mexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits, legal range 2..16.
REQ-002 Parameter IDLE_LEVEL, default 0: level driven on sout while no frame is active.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted at 0); release is synchronised externally.
REQ-005 load_valid  input  1  d_in and direc carry a word to transmit.
REQ-006 load_ready  output  1  block accepts a word this cycle.
REQ-007 d_in  input  WIDTH  parallel word to serialise.
REQ-008 direc  input  1  bit order for the word: 1 = MSB first, 0 = LSB first; sampled only on acceptance.
REQ-009 sout  output  1  serial data, one bit per clock.
REQ-010 sout_valid  output  1  sout carries a frame bit.
REQ-011 frame_start  output  1  high with the first bit of each frame.
REQ-012 busy  output  1  high while in state SHIFT.

Function
REQ-013 Acceptance occurs at a rising edge where load_valid=1 and load_ready=1; the word and direc are captured into the shift register and order flag.
REQ-014 FSM states: IDLE and SHIFT; IDLE->SHIFT on acceptance; SHIFT->IDLE after the last bit with no new acceptance; SHIFT->SHIFT on back-to-back acceptance.
REQ-015 Latency: the first bit appears on sout, with sout_valid=1 and frame_start=1, in the cycle after acceptance.
REQ-016 Each frame drives exactly WIDTH consecutive bits with sout_valid=1; there are no gaps within a frame.
REQ-017 When direc=1, bits go out d_in[WIDTH-1] down to d_in[0]; when direc=0, bits go out d_in[0] up to d_in[WIDTH-1].
REQ-018 A down-counter loads WIDTH-1 on acceptance and decrements once per bit; the last bit is the one where count=0.
REQ-019 load_ready=1 in IDLE and in SHIFT when count=0; otherwise load_ready=0.
REQ-020 Back-to-back: acceptance during the last bit makes the next frame's first bit follow immediately, with no idle cycle and frame_start=1.
REQ-021 In IDLE: sout=IDLE_LEVEL, sout_valid=0, frame_start=0, busy=0.
REQ-022 load_valid while load_ready=0 is ignored; d_in and direc changes mid-frame do not affect the frame in flight.
REQ-023 Outputs are registered; sout, sout_valid and frame_start have no combinational path from inputs.

Reset
REQ-024 While rst=0: state=IDLE, shift register=0, count=0, order flag=1, sout=IDLE_LEVEL, sout_valid=0, frame_start=0, busy=0, load_ready=0.
REQ-025 load_ready rises in the first cycle after rst release.
REQ-026 Reset asserted mid-frame aborts the frame immediately and asynchronously; no remaining bits are emitted after release.

Structure
REQ-027 Shared package tx_pkg holds the state encoding (IDLE, SHIFT) and the WIDTH default constant.
REQ-028 The bit counter is one sub-module, bit_cnt (parameterised width, load/decrement/zero flag); the shift datapath and FSM stay in piso_tx.

Verification
REQ-029 Reset then load d_in=4'b1001, direc=1 -> sout 1,0,0,1 in cycles 1-4 after acceptance; frame_start only in cycle 1.
REQ-030 Load d_in=4'b1011, direc=0 -> sout 1,1,0,1; sout_valid high for exactly 4 cycles, then sout=IDLE_LEVEL.
REQ-031 Hold load_valid=1 with 4'b1100/direc=1, then 4'b0011/direc=0 at the last bit -> 8 contiguous valid bits 1,1,0,0,1,1,0,0 with two frame_start pulses.
REQ-032 Assert rst=0 after the second bit of 4'b1111 -> sout=IDLE_LEVEL and sout_valid=0 at once, and no further bits after release.
REQ-033 Toggle load_valid, d_in and direc mid-frame -> load_ready=0, and the in-flight frame is unchanged.
REQ-034 WIDTH=8, load 8'hA5 with direc=0 -> sout 1,0,1,0,0,1,0,1.
